// File: rtl/keypad_bcd_entry.sv
// keypad_bcd_entry
//
// Scanned 4x4 matrix keypad receiver. The rows are driven one at a time,
// active-low, stepping once per scan tick. The columns are read back through
// a synchronizer. A key is accepted once its column has read low on
// DEB_TICKS consecutive ticks. It is released once all columns have read
// high on DEB_TICKS consecutive ticks.
//
// Accepted digit keys shift into a two-digit packed BCD entry register.
// '*' (code E) clears the entry. '#' (code F) publishes the entry on VALUE
// and pulses VALID. A-D only produce a strobe.
//
// Parameters
//   SCAN_BIT   scan tick period is 2^SCAN_BIT CLK cycles
//   DEB_TICKS  identical consecutive samples needed to accept a press or a
//              release (2..15)
//
// Ports
//   CLK         system clock
//   RESET       asynchronous, active-low reset
//   COL[3:0]    keypad columns, active-low, asynchronous to CLK
//   ROW[3:0]    keypad row drive, one-hot active-low
//   BCD[7:0]    live entry register {tens, units}
//   VALUE[7:0]  last value entered with '#'
//   VALID       one-cycle pulse when VALUE is updated
//   KEY[3:0]    code of the last accepted key
//   KEY_STROBE  one-cycle pulse on every accepted key
module keypad_bcd_entry #(
    parameter int SCAN_BIT  = 11,
    parameter int DEB_TICKS = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] COL,
    output logic [3:0] ROW,
    output logic [7:0] BCD,
    output logic [7:0] VALUE,
    output logic       VALID,
    output logic [3:0] KEY,
    output logic       KEY_STROBE
);

    localparam logic [SCAN_BIT-1:0] DIV_ONE  = 1;
    localparam logic [3:0]          DEB_LAST = 4'(DEB_TICKS);
    localparam logic [3:0]          CODE_CLR = 4'hE;
    localparam logic [3:0]          CODE_ENT = 4'hF;

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HELD,
        S_RELEASE
    } state_t;

    state_t              state, state_n;
    logic [SCAN_BIT-1:0] div_cnt;
    logic                tick;
    logic [3:0]          sync_a, scol;
    logic [3:0]          cnt, cnt_n, cnt_inc;
    logic [1:0]          cap_col, cap_col_n;
    logic [3:0]          row_q, row_n;
    logic [1:0]          row_sel;
    logic                any_low;
    logic [1:0]          win_col;
    logic                accept;
    logic [3:0]          code;

    // Key code for a (row, column) position of the matrix.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'hE;
            4'hD: k = 4'h0;
            4'hE: k = 4'hF;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    // The tick is registered. It is high for the one cycle in which the
    // divider sits at 0 after wrapping, and not at the reset value.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
            tick    <= (div_cnt == '1);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync_a <= 4'hF;
            scol   <= 4'hF;
        end else begin
            sync_a <= COL;
            scol   <= sync_a;
        end
    end

    // When several columns are low, the lowest column index wins.
    always_comb begin
        any_low = ~&scol;
        if (!scol[0])      win_col = 2'd0;
        else if (!scol[1]) win_col = 2'd1;
        else if (!scol[2]) win_col = 2'd2;
        else               win_col = 2'd3;
    end

    // Outside SCAN, ROW is frozen, so it doubles as the captured row.
    always_comb begin
        case (row_q)
            4'b1110: row_sel = 2'd0;
            4'b1101: row_sel = 2'd1;
            4'b1011: row_sel = 2'd2;
            default: row_sel = 2'd3;
        endcase
    end

    assign code    = key_code(row_sel, cap_col);
    assign cnt_inc = cnt + 4'd1;
    assign ROW     = row_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= S_SCAN;
            cnt     <= 4'd0;
            cap_col <= 2'd0;
            row_q   <= 4'b1110;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            cap_col <= cap_col_n;
            row_q   <= row_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cap_col_n = cap_col;
        row_n     = row_q;
        accept    = 1'b0;
        if (tick) begin
            case (state)
                S_SCAN: begin
                    if (any_low) begin
                        cap_col_n = win_col;
                        cnt_n     = 4'd1;
                        state_n   = S_DEBOUNCE;
                    end else begin
                        row_n = {row_q[2:0], row_q[3]};
                    end
                end
                S_DEBOUNCE: begin
                    if (any_low && (win_col == cap_col)) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == DEB_LAST) begin
                            accept  = 1'b1;
                            state_n = S_HELD;
                        end
                    end else begin
                        // Bounce or a different column: rescan this row.
                        state_n = S_SCAN;
                    end
                end
                S_HELD: begin
                    if (!any_low) begin
                        cnt_n   = 4'd1;
                        state_n = S_RELEASE;
                    end
                end
                default: begin
                    if (!any_low) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == DEB_LAST) begin
                            state_n = S_SCAN;
                            row_n   = {row_q[2:0], row_q[3]};
                        end
                    end else begin
                        state_n = S_HELD;
                    end
                end
            endcase
        end
    end

    // Accept actions. Everything updates on the same edge as the transition
    // into HELD.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            BCD        <= 8'h00;
            VALUE      <= 8'h00;
            VALID      <= 1'b0;
            KEY        <= 4'h0;
            KEY_STROBE <= 1'b0;
        end else begin
            KEY_STROBE <= accept;
            VALID      <= 1'b0;
            if (accept) begin
                KEY <= code;
                if (code <= 4'd9) begin
                    BCD <= {BCD[3:0], code};
                end else if (code == CODE_CLR) begin
                    BCD <= 8'h00;
                end else if (code == CODE_ENT) begin
                    VALUE <= BCD;
                    BCD   <= 8'h00;
                    VALID <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Bench for keypad_bcd_entry with SCAN_BIT=2 (tick every 4 cycles) and
// DEB_TICKS=3. A keypad model closes switches between the driven row and
// the columns. Expected results come from a vector table and from a
// digit-level model of the entry/value registers.
module tb_keypad_bcd_entry;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] COL;
    logic [3:0] ROW;
    logic [7:0] BCD;
    logic [7:0] VALUE;
    logic       VALID;
    logic [3:0] KEY;
    logic       KEY_STROBE;

    keypad_bcd_entry #(.SCAN_BIT(2), .DEB_TICKS(3)) dut (
        .CLK(CLK), .RESET(RESET), .COL(COL), .ROW(ROW), .BCD(BCD),
        .VALUE(VALUE), .VALID(VALID), .KEY(KEY), .KEY_STROBE(KEY_STROBE)
    );

    always #5 CLK = ~CLK;

    // Pressed switches: bit r*4+c closes row r onto column c.
    logic [15:0] pressed = 16'h0000;
    always_comb begin
        COL = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !ROW[r]) COL[c] = 1'b0;
    end

    int checks = 0;
    int errors = 0;

    // Strobe monitor: counts strobes and flags pulse-shape violations.
    int   strobe_total = 0;
    int   mon_err = 0;
    logic prev_strobe = 1'b0;
    always @(negedge CLK) begin
        if (KEY_STROBE) strobe_total <= strobe_total + 1;
        if ((KEY_STROBE && prev_strobe) || (VALID && !KEY_STROBE)) mon_err <= mon_err + 1;
        prev_strobe <= KEY_STROBE;
    end

    // Digit-level reference model.
    int m_tens = 0, m_units = 0, m_value = 0;

    function automatic logic [3:0] code_of(int r, int c);
        if (r < 3 && c < 3) return 4'(r * 3 + c + 1);
        if (c == 3) return (r == 3) ? 4'hD : 4'(10 + r);
        if (c == 0) return 4'hE;
        if (c == 1) return 4'h0;
        return 4'hF;
    endfunction

    task automatic model_apply(input logic [3:0] k);
        if (k <= 4'd9) begin
            m_tens = m_units;
            m_units = int'(k);
        end else if (k == 4'hE) begin
            m_tens = 0; m_units = 0;
        end else if (k == 4'hF) begin
            m_value = m_tens * 10 + m_units;
            m_tens = 0; m_units = 0;
        end
    endtask

    function automatic logic [7:0] dec2bcd(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n * 4) @(negedge CLK);
    endtask

    task automatic wait_strobe(output bit found);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (KEY_STROBE) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Returns at the first negedge on which row 1 has just been driven.
    task automatic align_row1(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (ROW != 4'b1101) break;
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (ROW == 4'b1101) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic press_key(input logic [15:0] mask, input string name, input logic [3:0] ek,
                             input logic [7:0] eb, input logic [7:0] ev, input logic evl);
        int  s0;
        bit  found;
        s0 = strobe_total;
        pressed = mask;
        wait_strobe(found);
        chk({name, " strobe"}, {7'h0, found}, 8'h01);
        if (found) begin
            chk({name, " KEY"}, {4'h0, KEY}, {4'h0, ek});
            chk({name, " BCD"}, BCD, eb);
            chk({name, " VALUE"}, VALUE, ev);
            chk({name, " VALID"}, {7'h0, VALID}, {7'h0, evl});
        end
        ticks(6);
        pressed = 16'h0000;
        ticks(10);
        chk({name, " single strobe"}, 8'(strobe_total - s0), 8'd1);
    endtask

    typedef struct {
        logic [15:0] mask;
        logic [3:0]  key;
        logic [7:0]  bcd;
        logic [7:0]  value;
        logic        valid;
    } vec_t;
    vec_t tbl[13];

    initial begin
        int  steps, last_i, bad_row, bad_out, s0, r, c;
        bit  ok, found;
        logic [3:0]  prev_row, k;
        logic [15:0] mask;

        tbl[0]  = '{16'h0020, 4'h5, 8'h05, 8'h00, 1'b0};
        tbl[1]  = '{16'h0100, 4'h7, 8'h57, 8'h00, 1'b0};
        tbl[2]  = '{16'h4000, 4'hF, 8'h00, 8'h57, 1'b1};
        tbl[3]  = '{16'h0020, 4'h5, 8'h05, 8'h57, 1'b0};
        tbl[4]  = '{16'h0100, 4'h7, 8'h57, 8'h57, 1'b0};
        tbl[5]  = '{16'h0001, 4'h1, 8'h71, 8'h57, 1'b0};
        tbl[6]  = '{16'h1000, 4'hE, 8'h00, 8'h57, 1'b0};
        tbl[7]  = '{16'h0008, 4'hA, 8'h00, 8'h57, 1'b0};
        tbl[8]  = '{16'h0400, 4'h9, 8'h09, 8'h57, 1'b0};
        tbl[9]  = '{16'h2000, 4'h0, 8'h90, 8'h57, 1'b0};
        tbl[10] = '{16'h8000, 4'hD, 8'h90, 8'h57, 1'b0};
        tbl[11] = '{16'h4000, 4'hF, 8'h00, 8'h90, 1'b1};
        tbl[12] = '{16'h0005, 4'h1, 8'h01, 8'h90, 1'b0};

        // Reset values.
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset ROW", {4'h0, ROW}, 8'h0E);
        chk("reset BCD", BCD, 8'h00);
        chk("reset VALUE", VALUE, 8'h00);
        chk("reset KEY", {4'h0, KEY}, 8'h00);
        chk("reset VALID", {7'h0, VALID}, 8'h00);
        chk("reset STROBE", {7'h0, KEY_STROBE}, 8'h00);
        RESET = 1'b1;

        // Idle scanning: one rotation step per tick, nothing else moves.
        steps = 0; last_i = 0; bad_row = 0; bad_out = 0; prev_row = ROW;
        for (int i = 0; i < 80; i++) begin
            @(negedge CLK);
            if (ROW != prev_row) begin
                if (ROW != {prev_row[2:0], prev_row[3]}) bad_row++;
                if (steps > 0 && (i - last_i) != 4) bad_row++;
                steps++;
                last_i = i;
                prev_row = ROW;
            end
            if (BCD != 8'h00 || VALUE != 8'h00 || KEY != 4'h0 || VALID || KEY_STROBE) bad_out++;
        end
        chk("idle rotation steps", {7'h0, (steps >= 19 && steps <= 20)}, 8'h01);
        chk("idle rotation order", 8'(bad_row), 8'd0);
        chk("idle outputs quiet", 8'(bad_out), 8'd0);

        // Table-driven key entry.
        foreach (tbl[i]) begin
            model_apply(tbl[i].key);
            press_key(tbl[i].mask, $sformatf("vec%0d", i), tbl[i].key,
                      tbl[i].bcd, tbl[i].value, tbl[i].valid);
        end

        // Bounce: exactly two low samples on row1/col1 is not enough.
        s0 = strobe_total;
        align_row1(ok);
        chk("bounce align", {7'h0, ok}, 8'h01);
        pressed = 16'h0020;
        repeat (8) @(negedge CLK);
        pressed = 16'h0000;
        ticks(8);
        chk("bounce no strobe", 8'(strobe_total - s0), 8'd0);
        chk("bounce BCD", BCD, {4'(m_tens), 4'(m_units)});

        // Release glitch of one tick while held: still a single strobe.
        s0 = strobe_total;
        model_apply(4'h5);
        pressed = 16'h0020;
        wait_strobe(found);
        chk("glitch strobe", {7'h0, found}, 8'h01);
        chk("glitch BCD", BCD, {4'(m_tens), 4'(m_units)});
        ticks(3);
        pressed = 16'h0000;
        repeat (4) @(negedge CLK);
        pressed = 16'h0020;
        ticks(4);
        pressed = 16'h0000;
        ticks(10);
        chk("glitch single strobe", 8'(strobe_total - s0), 8'd1);

        // Randomized presses against the digit-level model.
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            mask = 16'h0001 << (r * 4 + c);
            if (c < 3 && $urandom_range(0, 3) == 0)
                mask |= 16'h0001 << (r * 4 + $urandom_range(c + 1, 3));
            k = code_of(r, c);
            model_apply(k);
            press_key(mask, $sformatf("rand%0d", n), k, {4'(m_tens), 4'(m_units)},
                      dec2bcd(m_value), (k == 4'hF));
        end

        // Reset in DEBOUNCE with two samples counted.
        s0 = strobe_total;
        align_row1(ok);
        chk("rst align", {7'h0, ok}, 8'h01);
        pressed = 16'h0020;
        repeat (9) @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("rst async ROW", {4'h0, ROW}, 8'h0E);
        chk("rst async BCD", BCD, 8'h00);
        chk("rst async VALUE", VALUE, 8'h00);
        chk("rst async KEY", {4'h0, KEY}, 8'h00);
        chk("rst async STROBE", {7'h0, KEY_STROBE}, 8'h00);
        pressed = 16'h0000;
        m_tens = 0; m_units = 0; m_value = 0;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        chk("rst restart ROW", {4'h0, ROW}, 8'h0E);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (ROW != 4'b1110) begin
                ok = (ROW == 4'b1101);
                break;
            end
        end
        chk("rst first step", {7'h0, ok}, 8'h01);
        ticks(6);
        chk("rst no strobe", 8'(strobe_total - s0), 8'd0);
        chk("rst BCD after", BCD, 8'h00);

        chk("strobe pulse shape", 8'(mon_err), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/keypad_bcd_entry.md
# keypad_bcd_entry

Scanned 4x4 matrix keypad receiver that turns keypresses into a two-digit packed BCD value. It is the input-side counterpart of the board's scanned 7-segment BCD display path. Rows are driven one-hot active-low from a clock divider tick, columns are read back, and each key is debounced and decoded. Digit keys shift into an entry register; clear and enter keys manage the value handed to downstream logic.

## Interface
- SCAN_BIT, default 11: scan tick period is 2^SCAN_BIT CLK cycles.
- DEB_TICKS, default 8: number of consecutive identical scan samples needed to accept a press or a release (legal range 2..15).
- CLK  input  1  system clock.
- RESET  input  1  reset, asynchronous, active-low.
- COL  input  4  keypad columns, active-low, asynchronous to CLK.
- ROW  output  4  keypad row drive, one-hot active-low.
- BCD  output  8  live entry register; [7:4] is the tens digit, [3:0] is the units digit.
- VALUE  output  8  last entered BCD value.
- VALID  output  1  one-cycle pulse when VALUE is updated.
- KEY  output  4  code of the last accepted key.
- KEY_STROBE  output  1  one-cycle pulse on every accepted key.

## Operation
- Divider: a free-running SCAN_BIT-bit counter. TICK is a one-cycle pulse each time the counter wraps to 0.
- COL passes through a 2-flop synchronizer to give SCOL. All decisions use SCOL, sampled only on TICK.
- Key map as (row, col) -> code:
  - row0: 1, 2, 3, A
  - row1: 4, 5, 6, B
  - row2: 7, 8, 9, C
  - row3: E(*), 0, F(#), D
- If several columns are low, the lowest column index wins.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE. It holds a 4-bit sample counter CNT and the captured row/column.
  - SCAN, on TICK:
    - If any SCOL bit is low: capture the row and winning column, set CNT=1, go to DEBOUNCE. ROW is unchanged.
    - Otherwise rotate ROW to the next row: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - DEBOUNCE, on TICK:
    - If the same column is still the winning low column: CNT++.
    - When CNT reaches DEB_TICKS: accept the key and go to HELD.
    - Any other reading (including all high): go to SCAN with ROW unchanged and no strobe.
  - HELD, on TICK: if SCOL is all high, set CNT=1 and go to RELEASE.
  - RELEASE, on TICK:
    - If all high: CNT++. When CNT reaches DEB_TICKS, go to SCAN and rotate ROW.
    - If any bit is low: return to HELD.
- Accept actions (registered, all in the same cycle):
  - KEY is set to the code and KEY_STROBE pulses.
  - Code 0-9: BCD becomes {BCD[3:0], code}, so the old tens digit is discarded.
  - E: BCD becomes 00. VALUE is unchanged.
  - F: VALUE takes BCD, BCD becomes 00, and VALID pulses together with KEY_STROBE.
  - A-D: KEY_STROBE only. BCD and VALUE are unchanged.
- BCD nibbles only ever hold 0-9 by construction. No arithmetic is performed on them.
- A key held indefinitely produces exactly one strobe. There is no auto-repeat.

## Timing
- Reset values:
  - ROW=1110, BCD=00, VALUE=00, KEY=0, VALID=0, KEY_STROBE=0.
  - FSM in SCAN, divider=0, CNT=0, synchronizer flops high.
- Reset is asynchronous. Asserting it in any state, including mid-DEBOUNCE or mid-RELEASE, forces the reset values immediately and suppresses any pending strobe.
- ROW changes only in the cycle after a TICK. COL is sampled one full tick period later, so row settle time is guaranteed.
- Acceptance latency:
  - The first low sample counts as sample 1.
  - KEY_STROBE asserts on the CLK edge after the TICK that carries sample DEB_TICKS.
  - That is at most (DEB_TICKS-1)*2^SCAN_BIT + 3 cycles after the synchronized edge, plus row-alignment time.
- VALID and KEY_STROBE are exactly one CLK cycle wide and never back-to-back. The minimum spacing is 2*DEB_TICKS ticks.
- Simultaneous events:
  - A TICK coinciding with an accept is handled in the same edge.
  - A press on another row while in HELD or RELEASE is ignored. Only the captured row is driven.

## Test plan
All scenarios use SCAN_BIT=2 (TICK every 4 cycles) and DEB_TICKS=3.
- Reset, then no key for 20 ticks -> ROW cycles 1110, 1101, 1011, 0111, 1110 with one step per tick; all other outputs stay at reset values.
- Press '5' (row1, col1) for 10 ticks, release for 5 ticks, then press '7' the same way -> two single KEY_STROBE pulses with KEY=5 then KEY=7; BCD goes 05 then 57.
- Bounce: hold col1 low for 2 ticks on row1, then high -> no KEY_STROBE and BCD unchanged. A release glitch of 1 high tick in HELD produces no second strobe.
- With BCD=57, press '#' -> VALID and KEY_STROBE pulse in the same single cycle; VALUE=57, BCD=00, KEY=F.
- With BCD=57, press '1' -> BCD=71. Then press '*' -> BCD=00, VALUE keeps its prior value, VALID stays 0. Pressing row0 col0 and col2 together gives KEY=1 (lowest column wins).
- Assert RESET during DEBOUNCE with CNT=2 -> all outputs return to reset values asynchronously, no strobe occurs, and the FSM restarts in SCAN at ROW=1110.
